alu_seq: RTL

- Parametrised, clocked successor to the processor's combinational ALU.
- Adds a registered handshake (start/busy/done) and a multi-cycle signed shift-add multiplier that produces low-half and high-half products.
- Keeps the existing operand-select scheme (register, switches, immediate) and the V,N,Z,C flag vector.
- Sits between the register file/decoder and the writeback mux. The controller stalls on busy.

---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake: single-cycle RA/RB/RADD/RSUB and a
// multi-cycle signed shift-add multiplier returning the low or high product half.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   func,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [1:0]   a_sel,
  input  logic [1:0]   b_sel,
  input  logic [N:0]   switches,
  input  logic [N-1:0] immediate,
  input  logic         imm,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam logic [2:0] F_RA   = 3'b000;
  localparam logic [2:0] F_RB   = 3'b001;
  localparam logic [2:0] F_RADD = 3'b010;
  localparam logic [2:0] F_RSUB = 3'b011;
  localparam logic [2:0] F_MULL = 3'b100;
  localparam logic [2:0] F_MULH = 3'b101;

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [N:0]       ONE_W    = {{N{1'b0}}, 1'b1};
  localparam logic [2*N-1:0]   ONE_2W   = {{(2*N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t state, state_nxt;

  // Operand mux shared by both ports; encoding 11 falls back to the register value.
  function automatic logic [N-1:0] sel_operand(input logic [1:0] sel,
                                               input logic [N-1:0] reg_val,
                                               input logic [N:0] sw);
    case (sel)
      2'b01:   return sw[N-1:0];
      2'b10:   return {N{sw[N]}};
      default: return reg_val;
    endcase
  endfunction

  // N+1 bits so that -2^(N-1) has a representable magnitude.
  function automatic logic [N:0] magnitude(input logic signed [N-1:0] v);
    logic [N:0] ext;
    ext = {v[N-1], v};
    return v[N-1] ? (~ext + ONE_W) : ext;
  endfunction

  function automatic logic [3:0] pack_flags(input logic v, input logic [N-1:0] res,
                                            input logic c);
    return {v, res[N-1], (res == '0), c};
  endfunction

  function automatic logic mull_overflow(input logic signed [2*N-1:0] p);
    logic [N:0] top;
    top = p[2*N-1:N-1];
    return !((&top) || (top == '0));
  endfunction

  logic signed [N-1:0] a_eff, b_eff;
  logic [N:0]          add_w, sub_w;
  logic [N-1:0]        sc_res;
  logic                sc_v, sc_c;
  logic                accept, is_mul;
  logic [N:0]          mag_a, mag_b;

  logic [CNT_W-1:0]    cnt;
  logic [2:0]          func_p1;
  logic                neg_p1;
  logic [2*N-1:0]      acc_p1;
  logic [2*N-1:0]      mcand_p1;
  logic [N:0]          mplier_p1;

  logic signed [2*N-1:0] prod;
  logic [N-1:0]        mul_res;
  logic                mul_v;

  assign a_eff  = sel_operand(a_sel, a_in, switches);
  assign b_eff  = imm ? immediate : sel_operand(b_sel, b_in, switches);
  assign add_w  = {1'b0, a_eff} + {1'b0, b_eff};
  assign sub_w  = {1'b0, a_eff} + {1'b0, ~b_eff} + ONE_W;
  assign mag_a  = magnitude(a_eff);
  assign mag_b  = magnitude(b_eff);
  assign is_mul = (func == F_MULL) || (func == F_MULH);
  assign accept = start && (state == IDLE);
  assign busy   = (state != IDLE);

  always_comb begin
    sc_res = a_eff;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    case (func)
      F_RA: sc_res = a_eff;
      F_RB: sc_res = b_eff;
      F_RADD: begin
        {sc_c, sc_res} = add_w;
        sc_v = (a_eff[N-1] == b_eff[N-1]) && (add_w[N-1] != a_eff[N-1]);
      end
      F_RSUB: begin
        {sc_c, sc_res} = sub_w;
        sc_v = (a_eff[N-1] != b_eff[N-1]) && (sub_w[N-1] != a_eff[N-1]);
      end
      default: sc_res = a_eff;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (cnt == CNT_LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= '0;
      else if (state == MUL)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Stage p1: latched operand magnitudes, then one partial-product step per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      func_p1   <= func;
      neg_p1    <= a_eff[N-1] ^ b_eff[N-1];
      acc_p1    <= '0;
      mcand_p1  <= {{(N-1){1'b0}}, mag_a};
      mplier_p1 <= mag_b;
    end else if (state == MUL) begin
      if (mplier_p1[0])
        acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  assign prod    = neg_p1 ? (~acc_p1 + ONE_2W) : acc_p1;
  assign mul_res = (func_p1 == F_MULH) ? prod[2*N-1:N] : prod[N-1:0];
  assign mul_v   = (func_p1 == F_MULL) && mull_overflow(prod);

  // Stage out: result/flags update together with the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIN) begin
        result <= mul_res;
        flags  <= pack_flags(mul_v, mul_res, 1'b0);
        done   <= 1'b1;
      end else if (accept && !is_mul) begin
        result <= sc_res;
        flags  <= pack_flags(sc_v, sc_res, sc_c);
        done   <= 1'b1;
      end
    end
  end

endmodule
